// File: rtl/hwpe_axi_addressgen_sink_pkg.sv
// Shared types for the write-side (sink) address generator.
// Holds the stream configuration payload, its counter-width default and the sink FSM states.
package hwpe_axi_addressgen_sink_pkg;

    localparam int unsigned DEFAULT_STREAM_COUNTER_BITS = 16;
    localparam int unsigned CFG_ADDR_WIDTH              = 32;
    localparam int unsigned STRIDE_WIDTH                = 16;

    // Transfer descriptor: sizes/lengths are in words, strides in bytes (signed 16-bit).
    typedef struct packed {
        logic [CFG_ADDR_WIDTH-1:0]              base_addr;
        logic [DEFAULT_STREAM_COUNTER_BITS-1:0] trans_size;
        logic [STRIDE_WIDTH-1:0]                line_stride;
        logic [DEFAULT_STREAM_COUNTER_BITS-1:0] line_length;
        logic [STRIDE_WIDTH-1:0]                feat_stride;
        logic [DEFAULT_STREAM_COUNTER_BITS-1:0] feat_length;
    } stream_config_t;

    typedef enum logic [1:0] {
        SINK_IDLE = 2'd0,
        SINK_RUN  = 2'd1,
        SINK_DONE = 2'd2
    } sink_state_e;

endpackage

// File: rtl/hwpe_addressgen_counter3.sv
// Three-level word/line/feature counter with per-level stride accumulation.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear_i               zero all counters and offsets
//   step_i                advance by one NPX-word beat
//   line_length_i         words per line (multiple of NPX, nonzero)
//   feat_length_i         lines per feature
//   line_stride_i         signed byte stride between lines
//   feat_stride_i         signed byte stride between features
//   offset_o              word + line + feature byte offset
module hwpe_addressgen_counter3
    import hwpe_axi_addressgen_sink_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = DEFAULT_STREAM_COUNTER_BITS,
    parameter int unsigned NPX         = 4,
    parameter logic [31:0] WORD_STRIDE = 32'h2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    step_i,
    input  logic [CNT_WIDTH-1:0]    line_length_i,
    input  logic [CNT_WIDTH-1:0]    feat_length_i,
    input  logic [STRIDE_WIDTH-1:0] line_stride_i,
    input  logic [STRIDE_WIDTH-1:0] feat_stride_i,
    output logic [ADDR_WIDTH-1:0]   offset_o
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(NPX * WORD_STRIDE);
    localparam logic [CNT_WIDTH:0]    NPX_EXT   = (CNT_WIDTH+1)'(NPX);

    logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [ADDR_WIDTH-1:0] feat_addr_q, feat_addr_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]  feat_cnt_q, feat_cnt_d;
    logic [ADDR_WIDTH-1:0] line_stride_sext;
    logic [ADDR_WIDTH-1:0] feat_stride_sext;
    logic                  word_more_c;

    assign line_stride_sext = ADDR_WIDTH'($signed(line_stride_i));
    assign feat_stride_sext = ADDR_WIDTH'($signed(feat_stride_i));
    // Extra bit keeps word_cnt + NPX from wrapping near the counter limit.
    assign word_more_c = ({1'b0, word_cnt_q} + NPX_EXT) < {1'b0, line_length_i};
    assign offset_o    = word_addr_q + line_addr_q + feat_addr_q;

    // Next-state: word steps until the line is exhausted, then line, then feature.
    always_comb begin
        word_addr_d = word_addr_q;
        line_addr_d = line_addr_q;
        feat_addr_d = feat_addr_q;
        word_cnt_d  = word_cnt_q;
        line_cnt_d  = line_cnt_q;
        feat_cnt_d  = feat_cnt_q;
        if (clear_i) begin
            word_addr_d = '0;
            line_addr_d = '0;
            feat_addr_d = '0;
            word_cnt_d  = '0;
            line_cnt_d  = '0;
            feat_cnt_d  = '0;
        end else if (step_i) begin
            if (word_more_c) begin
                word_addr_d = word_addr_q + WORD_STEP;
                word_cnt_d  = word_cnt_q + CNT_WIDTH'(NPX);
            end else begin
                word_addr_d = '0;
                word_cnt_d  = '0;
                if (line_cnt_q < (feat_length_i - CNT_WIDTH'(1))) begin
                    line_addr_d = line_addr_q + line_stride_sext;
                    line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
                end else begin
                    line_addr_d = '0;
                    line_cnt_d  = '0;
                    feat_addr_d = feat_addr_q + feat_stride_sext;
                    feat_cnt_d  = feat_cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr_q <= '0;
            line_addr_q <= '0;
            feat_addr_q <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            feat_cnt_q  <= '0;
        end else begin
            word_addr_q <= word_addr_d;
            line_addr_q <= line_addr_d;
            feat_addr_q <= feat_addr_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            feat_cnt_q  <= feat_cnt_d;
        end
    end

endmodule

// File: rtl/hwpe_axi_addressgen_sink.sv
// Write-side address generator: turns NPX-pixel engine beats into per-lane TCDM
// write addresses and lane enables, walking a word/line/feature pattern.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start_i            pulse in IDLE: latch stream_config_i and begin
//   stream_config_i    transfer descriptor
//   valid_i / ready_o  engine beat handshake (ready_o is combinational on gnt_i)
//   req_o / gnt_i      TCDM write request / grant for the whole beat
//   addr_o             per-lane write address
//   lane_en_o          per-lane write enable (masks the partial last beat)
//   busy_o             transfer active
//   done_o             one-cycle pulse at transfer end
module hwpe_axi_addressgen_sink
    import hwpe_axi_addressgen_sink_pkg::*;
#(
    parameter int unsigned CLUS_ADDR_WIDTH     = 32,
    parameter logic [31:0] WORD_STRIDE         = 32'h2,
    parameter int unsigned STREAM_COUNTER_BITS = DEFAULT_STREAM_COUNTER_BITS,
    parameter int unsigned NPX                 = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  stream_config_t                       stream_config_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [NPX-1:0][CLUS_ADDR_WIDTH-1:0]  addr_o,
    output logic [NPX-1:0]                       lane_en_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int unsigned           CNT_W   = STREAM_COUNTER_BITS;
    localparam logic [CNT_W:0]        NPX_EXT = (CNT_W+1)'(NPX);

    sink_state_e                state_q, state_d;
    stream_config_t             cfg_q, cfg_d;
    logic [CNT_W-1:0]           ovr_cnt_q, ovr_cnt_d;
    logic [CNT_W-1:0]           trans_size_c;
    logic [CLUS_ADDR_WIDTH-1:0] offset_c;
    logic                       fire_c;
    logic                       last_c;
    logic                       clear_c;

    assign trans_size_c = CNT_W'(cfg_q.trans_size);
    assign fire_c       = (state_q == SINK_RUN) && valid_i && gnt_i;
    assign last_c       = ({1'b0, ovr_cnt_q} + NPX_EXT) >= {1'b0, trans_size_c};

    hwpe_addressgen_counter3 #(
        .ADDR_WIDTH  (CLUS_ADDR_WIDTH),
        .CNT_WIDTH   (CNT_W),
        .NPX         (NPX),
        .WORD_STRIDE (WORD_STRIDE)
    ) i_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_c),
        .step_i        (fire_c),
        .line_length_i (CNT_W'(cfg_q.line_length)),
        .feat_length_i (CNT_W'(cfg_q.feat_length)),
        .line_stride_i (cfg_q.line_stride),
        .feat_stride_i (cfg_q.feat_stride),
        .offset_o      (offset_c)
    );

    // Next-state and handshake/address outputs.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        ovr_cnt_d = ovr_cnt_q;
        clear_c   = 1'b0;
        ready_o   = 1'b0;
        req_o     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        lane_en_o = '0;
        addr_o    = '0;

        case (state_q)
            SINK_IDLE: begin
                if (start_i) begin
                    cfg_d     = stream_config_i;
                    ovr_cnt_d = '0;
                    clear_c   = 1'b1;
                    state_d   = (stream_config_i.trans_size == '0) ? SINK_DONE : SINK_RUN;
                end
            end
            SINK_RUN: begin
                busy_o  = 1'b1;
                req_o   = valid_i;
                ready_o = valid_i && gnt_i;
                for (int unsigned j = 0; j < NPX; j++) begin
                    addr_o[j]    = CLUS_ADDR_WIDTH'(cfg_q.base_addr) + offset_c
                                 + CLUS_ADDR_WIDTH'(j * WORD_STRIDE);
                    lane_en_o[j] = valid_i &&
                                   (({1'b0, ovr_cnt_q} + (CNT_W+1)'(j)) < {1'b0, trans_size_c});
                end
                if (fire_c) begin
                    ovr_cnt_d = ovr_cnt_q + CNT_W'(NPX);
                    if (last_c) begin
                        state_d = SINK_DONE;
                    end
                end
            end
            SINK_DONE: begin
                done_o  = 1'b1;
                state_d = SINK_IDLE;
            end
            default: begin
                state_d = SINK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SINK_IDLE;
            cfg_q     <= '0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

endmodule

// File: tb/tb_hwpe_axi_addressgen_sink.sv
// Self-checking bench for hwpe_axi_addressgen_sink: directed vector table,
// hand-written corner sequences and randomized transfers against a beat-level model.
module tb_hwpe_axi_addressgen_sink;
    import hwpe_axi_addressgen_sink_pkg::*;

    localparam int unsigned NPX = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned CW  = DEFAULT_STREAM_COUNTER_BITS;
    localparam logic [31:0] WS  = 32'h2;

    logic                     clk;
    logic                     rst_n;
    logic                     start_i;
    stream_config_t           cfg_i;
    logic                     valid_i;
    logic                     ready_o;
    logic                     req_o;
    logic                     gnt_i;
    logic [NPX-1:0][AW-1:0]   addr_o;
    logic [NPX-1:0]           lane_en_o;
    logic                     busy_o;
    logic                     done_o;

    int total = 0;
    int bad   = 0;

    hwpe_axi_addressgen_sink #(
        .CLUS_ADDR_WIDTH     (AW),
        .WORD_STRIDE         (WS),
        .STREAM_COUNTER_BITS (CW),
        .NPX                 (NPX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .stream_config_i (cfg_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .req_o           (req_o),
        .gnt_i           (gnt_i),
        .addr_o          (addr_o),
        .lane_en_o       (lane_en_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stream_config_t mk_cfg(input logic [31:0] base, input int trans, input int ll,
                                              input int fl, input logic [15:0] ls, input logic [15:0] fs);
        stream_config_t c;
        c.base_addr   = base;
        c.trans_size  = CW'(trans);
        c.line_length = CW'(ll);
        c.feat_length = CW'(fl);
        c.line_stride = ls;
        c.feat_stride = fs;
        return c;
    endfunction

    function automatic stream_config_t rand_cfg();
        return mk_cfg($urandom, int'($urandom_range(1, 40)), int'(NPX * $urandom_range(1, 4)),
                      int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom));
    endfunction

    // Beat b, lane j: decompose the beat index into word/line/feature positions.
    function automatic logic [31:0] model_addr(input stream_config_t c, input int b, input int j);
        int          bpl = int'(c.line_length) / NPX;
        int          w   = b % bpl;
        int          lt  = b / bpl;
        int          ln  = lt % int'(c.feat_length);
        int          ft  = lt / int'(c.feat_length);
        logic [31:0] ls  = {{16{c.line_stride[15]}}, c.line_stride};
        logic [31:0] fs  = {{16{c.feat_stride[15]}}, c.feat_stride};
        return c.base_addr + 32'(ft) * fs + 32'(ln) * ls + 32'(w * NPX) * WS + 32'(j) * WS;
    endfunction

    // Runs one transfer (trans_size >= 1), checking every cycle against the model.
    task automatic run_xfer(input stream_config_t c, input bit rand_hs, input bit poke,
                            output logic [0:3][31:0] a0_cap, output logic [3:0] last_en,
                            output int beats);
        int nb;
        int b;
        int cyc;
        logic [3:0] exp_en;
        nb      = (int'(c.trans_size) + NPX - 1) / NPX;
        b       = 0;
        cyc     = 0;
        a0_cap  = '0;
        last_en = '0;
        @(posedge clk); #1;
        cfg_i   = c;
        start_i = 1'b1;
        valid_i = 1'b0;
        gnt_i   = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (b < nb && cyc < 600) begin
            valid_i = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            gnt_i   = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
            cfg_i   = rand_cfg();
            start_i = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            for (int j = 0; j < NPX; j++)
                exp_en[j] = valid_i && ((b * NPX + j) < int'(c.trans_size));
            check("run_busy", busy_o, 1);
            check("run_done", done_o, 0);
            check("run_req", req_o, valid_i);
            check("run_ready", ready_o, valid_i && gnt_i);
            check("run_lane_en", lane_en_o, exp_en);
            for (int j = 0; j < NPX; j++)
                check("run_addr", addr_o[j], model_addr(c, b, j));
            if (valid_i && gnt_i) begin
                if (b < 4) a0_cap[b] = addr_o[0];
                last_en = lane_en_o;
                b++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("xfer_beats_in_budget", 64'(b), 64'(nb));
        start_i = 1'b0;
        valid_i = 1'b0;
        gnt_i   = 1'b0;
        @(negedge clk);
        check("end_done_pulse", done_o, 1);
        check("end_busy", busy_o, 0);
        check("end_req", req_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("end_done_cleared", done_o, 0);
        beats = b;
    endtask

    typedef struct {
        logic [31:0]      base;
        int               trans;
        int               ll;
        int               fl;
        logic [15:0]      ls;
        logic [15:0]      fs;
        bit               poke;
        int               beats;
        logic [0:3][31:0] a0;
        logic [3:0]       last_en;
    } vec_t;

    vec_t             vecs[4];
    logic [0:3][31:0] cap;
    logic [3:0]       len;
    int               nbt;
    stream_config_t   c;

    initial begin
        vecs[0] = '{base: 32'h1000, trans: 16, ll: 8,  fl: 2, ls: 16'h0040, fs: 16'h0000, poke: 1'b0,
                    beats: 4, a0: '{32'h1000, 32'h1008, 32'h1040, 32'h1048}, last_en: 4'b1111};
        vecs[1] = '{base: 32'h2000, trans: 10, ll: 12, fl: 1, ls: 16'h0000, fs: 16'h0000, poke: 1'b0,
                    beats: 3, a0: '{32'h2000, 32'h2008, 32'h2010, 32'h0}, last_en: 4'b0011};
        vecs[2] = '{base: 32'h3000, trans: 16, ll: 4,  fl: 2, ls: 16'h0010, fs: 16'hFFE0, poke: 1'b0,
                    beats: 4, a0: '{32'h3000, 32'h3010, 32'h2FE0, 32'h2FF0}, last_en: 4'b1111};
        vecs[3] = '{base: 32'h1000, trans: 16, ll: 8,  fl: 2, ls: 16'h0040, fs: 16'h0000, poke: 1'b1,
                    beats: 4, a0: '{32'h1000, 32'h1008, 32'h1040, 32'h1048}, last_en: 4'b1111};

        rst_n   = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        gnt_i   = 1'b0;
        cfg_i   = '0;
        #12;
        check("rst_ready", ready_o, 0);
        check("rst_req", req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_lane_en", lane_en_o, 0);
        for (int j = 0; j < NPX; j++) check("rst_addr", addr_o[j], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors with full handshake.
        for (int v = 0; v < 4; v++) begin
            c = mk_cfg(vecs[v].base, vecs[v].trans, vecs[v].ll, vecs[v].fl, vecs[v].ls, vecs[v].fs);
            run_xfer(c, 1'b0, vecs[v].poke, cap, len, nbt);
            check("vec_beats", 64'(nbt), 64'(vecs[v].beats));
            check("vec_last_en", len, vecs[v].last_en);
            for (int b = 0; b < vecs[v].beats; b++) check("vec_lane0_addr", cap[b], vecs[v].a0[b]);
        end

        // Grant withheld for 5 cycles after two beats.
        c = mk_cfg(32'h1000, 16, 8, 2, 16'h0040, 16'h0000);
        @(posedge clk); #1;
        cfg_i = c; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; valid_i = 1'b1; gnt_i = 1'b1;
        @(negedge clk); check("stall_b0", addr_o[0], 32'h1000);
        @(posedge clk); #1;
        @(negedge clk); check("stall_b1", addr_o[0], 32'h1008);
        @(posedge clk); #1;
        gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready", ready_o, 0);
            check("stall_req", req_o, 1);
            check("stall_addr", addr_o[0], 32'h1040);
            check("stall_en", lane_en_o, 4'b1111);
            @(posedge clk); #1;
        end
        gnt_i = 1'b1;
        @(negedge clk); check("resume_b2", addr_o[0], 32'h1040); check("resume_ready", ready_o, 1);
        @(posedge clk); #1;
        @(negedge clk); check("resume_b3", addr_o[0], 32'h1048);
        @(posedge clk); #1;
        valid_i = 1'b0; gnt_i = 1'b0;
        @(negedge clk); check("stall_done", done_o, 1);
        @(posedge clk); #1;

        // Zero-size transfer: immediate done, never a request.
        cfg_i = mk_cfg(32'h5000, 0, 8, 1, 16'h0, 16'h0);
        start_i = 1'b1; valid_i = 1'b1; gnt_i = 1'b1;
        @(negedge clk); check("zero_req_idle", req_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("zero_done", done_o, 1);
        check("zero_req", req_o, 0);
        check("zero_busy", busy_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_clr", done_o, 0);
        check("zero_req2", req_o, 0);
        check("zero_ready", ready_o, 0);
        @(posedge clk); #1;
        valid_i = 1'b0; gnt_i = 1'b0;

        // Reset after two beats, then restart from base.
        c = mk_cfg(32'h1000, 16, 8, 2, 16'h0040, 16'h0000);
        cfg_i = c; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; valid_i = 1'b1; gnt_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", ready_o, 0);
        check("arst_req", req_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_lane_en", lane_en_o, 0);
        for (int j = 0; j < NPX; j++) check("arst_addr", addr_o[j], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_done", done_o, 0);
            check("post_rst_idle", busy_o, 0);
            @(posedge clk); #1;
        end
        run_xfer(c, 1'b0, 1'b0, cap, len, nbt);
        for (int b = 0; b < 4; b++) check("restart_lane0_addr", cap[b], vecs[0].a0[b]);

        // Randomized transfers with random handshake and stray start pulses.
        for (int t = 0; t < 30; t++) begin
            run_xfer(rand_cfg(), 1'b1, 1'($urandom_range(0, 1)), cap, len, nbt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
